fetch_stage: RTL and testbench

Instruction fetch stage of the riscv-lite core, directly upstream of decode. Owns the PC and the current epoch colour. Issues in-order word reads to instruction memory and buffers responses in a small FIFO. Presents `{inst, pc, epoch}` to decode over a valid/ready handshake. On a redirect from execute it flips epoch, reloads PC, flushes buffered entries and discards in-flight responses.

---
 rtl/fetch_stage_pkg.sv | 36 +++
 rtl/fetch_stage_fifo.sv | 53 +++++
 rtl/fetch_stage.sv | 131 +++++++++++++
 tb/tb_fetch_stage.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared types for the fetch stage (word type, epoch colour,
// fetch FSM states, decode-bound entry) plus small helpers.
package fetch_stage_pkg;

    typedef logic [31:0] rvwordT;

    typedef enum logic {
        EPOCH_RED   = 1'b0,
        EPOCH_GREEN = 1'b1
    } EpochT;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_RUN,
        FS_DRAIN
    } FetchStateT;

    typedef struct packed {
        rvwordT inst;
        rvwordT pc;
        EpochT  epoch;
    } fetchEntryT;

    localparam rvwordT INST_BYTES = 32'd4;

    function automatic EpochT nextEpochColour(input EpochT e);
        return (e == EPOCH_RED) ? EPOCH_GREEN : EPOCH_RED;
    endfunction

    function automatic logic [31:0] satAdd32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/fetch_stage_fifo.sv
// fetch_fifo: small circular FIFO with push/pop/flush, occupancy count and a
// head read straight from registered storage.
// Ports: clk, rst (sync, active-high), push/din, pop, flush, head, count.
// Pop on empty is ignored; flush has priority over push/pop.
module fetch_fifo #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 65,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd;
    logic [PW-1:0]    wr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop && count != '0;
    assign do_push = push && (count != CW'(DEPTH) || do_pop);
    assign head    = mem[rd];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wr] <= din;
                wr      <= inc(wr);
            end
            if (do_pop) rd <= inc(rd);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with PC/epoch ownership, credit-limited
// in-order imem reads, output FIFO to decode and redirect/kill handling.
// Ports: clk, rst (sync, active-high), fetch_en, redirect_valid/redirect_pc,
// imem_req/imem_addr/imem_gnt, imem_rvalid/imem_rdata,
// out_valid/out_ready/out_inst/out_pc/out_epoch.
// Optional FETCH_STATS_EN adds stat_fetched and stat_killed (saturating).
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter rvwordT RESET_PC   = 32'h0000_0000,
    parameter int     FIFO_DEPTH = 3
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   fetch_en,
    input  logic   redirect_valid,
    input  rvwordT redirect_pc,
    output logic   imem_req,
    output rvwordT imem_addr,
    input  logic   imem_gnt,
    input  logic   imem_rvalid,
    input  rvwordT imem_rdata,
    output logic   out_valid,
    input  logic   out_ready,
    output rvwordT out_inst,
    output rvwordT out_pc,
    output EpochT  out_epoch
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] stat_fetched,
    output logic [31:0] stat_killed
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    FetchStateT    state;
    FetchStateT    state_nx;
    rvwordT        pc;
    EpochT         epoch;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] buf_count;
    logic [CW-1:0] kill_cnt;
    rvwordT        req_pc;
    fetchEntryT    head;
    logic          gnt;
    logic          rsp;
    logic          drop;
    logic          pop;

    // Credits cover both in-flight requests and buffered entries, so the
    // output FIFO can never overflow.
    assign imem_req  = state == FS_RUN && !redirect_valid &&
                       ({1'b0, outstanding} + {1'b0, buf_count}) < (CW + 1)'(FIFO_DEPTH);
    assign imem_addr = pc;
    assign gnt       = imem_req && imem_gnt;
    assign rsp       = imem_rvalid && outstanding != '0;
    // Any epoch change kills everything in flight, so surviving responses
    // always carry the current epoch.
    assign drop      = rsp && (redirect_valid || kill_cnt != '0);
    assign out_valid = buf_count != '0;
    assign pop       = out_valid && out_ready;
    assign out_inst  = head.inst;
    assign out_pc    = head.pc;
    assign out_epoch = head.epoch;

    fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(fetchEntryT))) u_out_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rsp && !drop),
        .din   ({imem_rdata, req_pc, epoch}),
        .pop   (pop),
        .flush (redirect_valid),
        .head  (head),
        .count (buf_count)
    );

    // Request PCs in issue order; its occupancy is the outstanding count.
    fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_pc_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (gnt),
        .din   (pc),
        .pop   (rsp),
        .flush (1'b0),
        .head  (req_pc),
        .count (outstanding)
    );

    always_comb begin
        state_nx = (state == FS_IDLE && fetch_en)          ? FS_RUN   :
                   (state == FS_RUN && !fetch_en)          ? FS_DRAIN :
                   (state == FS_DRAIN && outstanding == '0) ? FS_IDLE  : state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FS_IDLE;
            pc       <= RESET_PC;
            epoch    <= EPOCH_RED;
            kill_cnt <= '0;
        end else begin
            state <= state_nx;
            if (redirect_valid) begin
                pc       <= redirect_pc & ~rvwordT'(3);
                epoch    <= nextEpochColour(epoch);
                kill_cnt <= outstanding - CW'(rsp);
            end else begin
                if (gnt) pc <= pc + INST_BYTES;
                if (rsp && kill_cnt != '0) kill_cnt <= kill_cnt - 1'b1;
            end
        end
    end

`ifdef FETCH_STATS_EN
    logic [CW-1:0] flushed;
    assign flushed = redirect_valid ? buf_count - CW'(pop) : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_fetched <= '0;
            stat_killed  <= '0;
        end else begin
            stat_fetched <= satAdd32(stat_fetched, 32'(pop));
            stat_killed  <= satAdd32(stat_killed, 32'(flushed) + 32'(drop));
        end
    end
`endif

    rvalid_needs_outstanding: assert property (@(posedge clk) disable iff (rst)
        imem_rvalid |-> outstanding != '0);

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized bench with a queue-based reference model and a
// few directed sequences pinned by literal expectations.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic   clk = 0;
    logic   rst;
    logic   fetch_en;
    logic   redirect_valid;
    rvwordT redirect_pc;
    logic   imem_req;
    rvwordT imem_addr;
    logic   imem_gnt;
    logic   imem_rvalid;
    rvwordT imem_rdata;
    logic   out_valid;
    logic   out_ready;
    rvwordT out_inst;
    rvwordT out_pc;
    EpochT  out_epoch;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_killed;
`endif

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_epoch      (out_epoch)
`ifdef FETCH_STATS_EN
        ,
        .stat_fetched   (stat_fetched),
        .stat_killed    (stat_killed)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] inst; logic [31:0] pc; logic ep; } ent_t;
    typedef struct { logic [31:0] pc; int gen; } infl_t;
    typedef struct { logic [31:0] d; int gc; } mrsp_t;

    ent_t  outq[$];
    infl_t infl[$];
    mrsp_t mq[$];
    int    m_st;
    logic [31:0] m_pc;
    int    gen;
    bit    m_req;
    int    cyc;
    int    m_fetched;
    int    m_killed;
    int    tests;
    int    fails;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h want %h (cycle %0d)", n, a, e, cyc);
        end
    endtask

    task automatic model_reset();
        outq.delete();
        infl.delete();
        mq.delete();
        m_st = 0;
        m_pc = 32'h0;
        gen = 0;
        m_fetched = 0;
        m_killed = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        fetch_en = 0;
        redirect_valid = 0;
        redirect_pc = 0;
        out_ready = 0;
        imem_gnt = 0;
        imem_rvalid = 0;
        imem_rdata = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    task automatic drive(input bit fe, input bit rd, input logic [31:0] rpc,
                         input bit rdy, input bit g, input bit rvw);
        @(negedge clk);
        fetch_en = fe;
        redirect_valid = rd;
        redirect_pc = rpc;
        out_ready = rdy;
        imem_gnt = g;
        imem_rvalid = rvw && mq.size() != 0 && mq[0].gc < cyc;
        imem_rdata = imem_rvalid ? mq[0].d : $urandom;
        #1;
        m_req = m_st == 1 && !rd && (infl.size() + outq.size() < 3);
        chk("imem_req", imem_req, m_req);
        chk("imem_addr", imem_addr, m_pc);
        chk("out_valid", out_valid, outq.size() != 0);
        if (outq.size() != 0) begin
            chk("out_inst", out_inst, outq[0].inst);
            chk("out_pc", out_pc, outq[0].pc);
            chk("out_epoch", 32'(out_epoch), outq[0].ep);
        end
    endtask

    task automatic fin();
        bit    pop;
        bit    rsp;
        infl_t e;
        pop = outq.size() != 0 && out_ready;
        rsp = imem_rvalid && infl.size() != 0;
        m_st = (m_st == 0 && fetch_en) ? 1 :
               (m_st == 1 && !fetch_en) ? 2 :
               (m_st == 2 && infl.size() == 0) ? 0 : m_st;
        if (pop) begin
            outq.delete(0);
            m_fetched++;
        end
        if (rsp) begin
            e = infl.pop_front();
            if (redirect_valid || e.gen != gen) m_killed++;
            else outq.push_back('{inst: imem_rdata, pc: e.pc, ep: gen[0]});
        end
        if (redirect_valid) begin
            m_killed += outq.size();
            outq.delete();
            m_pc = redirect_pc & ~32'h3;
            gen++;
        end else if (m_req && imem_gnt) begin
            infl.push_back('{pc: m_pc, gen: gen});
            m_pc += 4;
        end
        if (imem_rvalid) mq.delete(0);
        if (imem_req && imem_gnt) mq.push_back('{d: $urandom, gc: cyc});
        cyc++;
    endtask

    initial begin
        int grants;
        bit seen;
        tests = 0;
        fails = 0;
        cyc = 0;
        model_reset();
        do_reset();

        // Start-up with 1-cycle memory and decode always ready.
        drive(1, 0, 0, 1, 1, 1);
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_oval", out_valid, 0);
        chk("rst_inst", out_inst, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_epoch", 32'(out_epoch), 0);
        fin();
        drive(1, 0, 0, 1, 1, 1);
        chk("c1_req", imem_req, 1);
        chk("c1_addr", imem_addr, 0);
        fin();
        drive(1, 0, 0, 1, 1, 1);
        chk("c2_addr", imem_addr, 4);
        chk("c2_oval", out_valid, 0);
        fin();
        drive(1, 0, 0, 1, 1, 1);
        chk("c3_oval", out_valid, 1);
        chk("c3_pc", out_pc, 0);
        chk("c3_addr", imem_addr, 8);
        fin();
        drive(1, 0, 0, 1, 1, 1);
        chk("c4_pc", out_pc, 4);
        fin();

        // Drain: no new requests, everything delivered.
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 1, 1, 1);
            fin();
        end
        drive(0, 0, 0, 1, 1, 1);
        chk("drain_req", imem_req, 0);
        chk("drain_oval", out_valid, 0);
        fin();

        // Backpressure from empty: exactly three grants then stall.
        grants = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 0, 0, 1, 1);
            if (imem_req) grants++;
            fin();
        end
        drive(1, 0, 0, 0, 1, 1);
        chk("bp_grants", grants, 3);
        chk("bp_req", imem_req, 0);
        chk("bp_oval", out_valid, 1);
        fin();
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 0, 1, 1, 1);
            fin();
        end

        // Redirect with two outstanding and one buffered.
        drive(1, 0, 0, 0, 1, 0);
        fin();
        drive(1, 1, 32'h0000_0103, 0, 1, 0);
        chk("rd_req", imem_req, 0);
        fin();
        drive(1, 0, 0, 1, 1, 1);
        chk("rd_oval", out_valid, 0);
        chk("rd_addr", imem_addr, 32'h100);
        chk("rd_nreq", imem_req, 1);
        fin();
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            drive(1, 0, 0, 1, 1, 1);
            if (out_valid) begin
                seen = 1;
                chk("rd_pc", out_pc, 32'h100);
                chk("rd_epoch", 32'(out_epoch), 32'(EPOCH_GREEN));
            end
            fin();
        end
        chk("rd_seen", seen, 1);

        // PC wrap at the top of the address space.
        drive(1, 1, 32'hFFFF_FFFC, 1, 1, 1);
        fin();
        drive(1, 0, 0, 1, 1, 1);
        chk("wrap_a0", imem_addr, 32'hFFFF_FFFC);
        chk("wrap_req", imem_req, 1);
        fin();
        drive(1, 0, 0, 1, 1, 1);
        chk("wrap_a1", imem_addr, 32'h0);
        fin();

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(999) == 0) do_reset();
            drive($urandom_range(9) != 0, $urandom_range(29) == 0, $urandom,
                  $urandom_range(9) < 7, $urandom_range(9) < 7, $urandom_range(9) < 6);
            fin();
        end

`ifdef FETCH_STATS_EN
        @(negedge clk);
        #1;
        chk("stat_fetched", stat_fetched, m_fetched);
        chk("stat_killed", stat_killed, m_killed);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
